// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator datapath: keycodes produced by the
// keypad encoder, operator codes understood by calcCoreLogic, the keypad
// scanner state encoding and the key-matrix helper functions.
// No ports (package).
// -----------------------------------------------------------------------------
package calc_pkg;

   // Digit keys are {DIGIT_PREFIX, value[3:0]}
   localparam logic       DIGIT_PREFIX = 1'b1;

   // calcCoreLogic operator codes, also the low bits of the operator keycodes
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_SUB = 2'b11;

   localparam logic [4:0] KEY_ADD = {3'b010, OP_ADD};
   localparam logic [4:0] KEY_MUL = {3'b010, OP_MUL};
   localparam logic [4:0] KEY_SUB = {3'b010, OP_SUB};
   localparam logic [4:0] KEY_SQR = 5'b01100;
   localparam logic [4:0] KEY_EQ  = 5'b00100;
   localparam logic [4:0] KEY_CE  = 5'b00001;
   localparam logic [4:0] KEY_DEL = 5'b00010;
   localparam logic [4:0] KEY_CA  = 5'b00011;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      EMIT     = 2'd2,
      RELEASE  = 2'd3
   } keypadState_t;

   // True when exactly one (active-low) column is pulled down
   function automatic logic oneColLow(input logic [3:0] col);
      logic hit;
      case (col)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: hit = 1'b1;
         default:                            hit = 1'b0;
      endcase
      return hit;
   endfunction

   // Index of the low column; only meaningful when oneColLow() is true
   function automatic logic [1:0] lowColIndex(input logic [3:0] col);
      logic [1:0] idx;
      case (col)
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   // Key index (row*4 + col) to keycode
   function automatic logic [4:0] keyEncode(input logic [4:0] idx);
      logic [4:0] code;
      code = {DIGIT_PREFIX, idx[3:0]};
      case (idx)
         5'd16:   code = KEY_ADD;
         5'd17:   code = KEY_MUL;
         5'd18:   code = KEY_SUB;
         5'd19:   code = KEY_SQR;
         5'd20:   code = KEY_EQ;
         5'd21:   code = KEY_CE;
         5'd22:   code = KEY_DEL;
         5'd23:   code = KEY_CA;
         default: ;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/keypad_sync_debounce.sv
// -----------------------------------------------------------------------------
// keypad_sync_debounce
// Two-flop synchronizer for the keypad columns plus a saturating counter that
// measures how long the synchronized columns have matched a reference pattern.
//   clock    in   system clock
//   reset    in   asynchronous active-low reset
//   col_in   in   raw keypad columns (active-low, asynchronous)
//   enable   in   counter runs only while high; cleared otherwise
//   pattern  in   reference column pattern to match
//   colS     out  synchronized columns
//   match    out  colS equals pattern this cycle
//   stable   out  pattern held for DEBOUNCE_CYCLES consecutive samples
// -----------------------------------------------------------------------------
module keypad_sync_debounce #(
   parameter int DEBOUNCE_CYCLES = 100000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] col_in,
   input  logic       enable,
   input  logic [3:0] pattern,
   output logic [3:0] colS,
   output logic       match,
   output logic       stable
);

   localparam int               CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [3:0]       colMeta_p0;
   logic [3:0]       colSync_p1;
   logic [CNT_W-1:0] stableCnt;

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   // Stage p0/p1: synchronizer; idle keypad reads all-high
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         colMeta_p0 <= 4'b1111;
         colSync_p1 <= 4'b1111;
      end else begin
         colMeta_p0 <= col_in;
         colSync_p1 <= colMeta_p0;
      end
   end

   assign colS  = colSync_p1;
   assign match = (colSync_p1 == pattern);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stableCnt <= '0;
      end else if (!enable || !match) begin
         stableCnt <= '0;
      end else begin
         stableCnt <= satInc(stableCnt);
      end
   end

   assign stable = enable && match && (stableCnt == CNT_MAX);

endmodule

// File: rtl/keypad_encoder.sv
// -----------------------------------------------------------------------------
// keypad_encoder
// Scans a 6x4 active-low key matrix, debounces press and release, and emits a
// 5-bit keycode with a one-cycle newkey strobe for calcCoreLogic.
//   clock      in   system clock
//   reset      in   asynchronous active-low reset
//   row_drive  out  row strobes, active-low, one-hot-zero
//   col_in     in   columns, active-low, asynchronous
//   newkey     out  one-cycle strobe: keycode is valid and new
//   keycode    out  encoded key, changes only with newkey
// Build option: define KEYPAD_REPEAT_EN for auto-repeat while a key is held.
// -----------------------------------------------------------------------------
module keypad_encoder
   import calc_pkg::*;
#(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int REPEAT_CYCLES   = 2500000
) (
   input  logic       clock,
   input  logic       reset,
   output logic [5:0] row_drive,
   input  logic [3:0] col_in,
   output logic       newkey,
   output logic [4:0] keycode
);

   localparam int               DIV_W    = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : gParamCheck
      $error("keypad_encoder: parameter below its minimum");
   end

   keypadState_t     state, nextState;
   logic [2:0]       rowIdx, rowNext;
   logic [1:0]       colIdx, colNext;
   logic [3:0]       colLatched, colLatchedNext;
   logic [DIV_W-1:0] divCnt, divNext;
   logic [3:0]       colS;
   logic [3:0]       dbPattern;
   logic             dbEnable;
   logic             match;
   logic             stable;
   logic             repFire;
   logic             newkeyNext;

   function automatic logic [2:0] nextRow(input logic [2:0] r);
      return (r == 3'd5) ? 3'd0 : r + 3'd1;
   endfunction

   // One counter serves both press debounce (latched pattern) and release
   // debounce (all columns high).
   assign dbEnable  = (state == DEBOUNCE) || (state == RELEASE);
   assign dbPattern = (state == RELEASE) ? 4'b1111 : colLatched;

   keypad_sync_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_syncDebounce (
      .clock   (clock),
      .reset   (reset),
      .col_in  (col_in),
      .enable  (dbEnable),
      .pattern (dbPattern),
      .colS    (colS),
      .match   (match),
      .stable  (stable)
   );

   assign row_drive = ~(6'd1 << rowIdx);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= SCAN;
         rowIdx     <= 3'd0;
         colIdx     <= 2'd0;
         colLatched <= 4'b1111;
         divCnt     <= '0;
         newkey     <= 1'b0;
         keycode    <= 5'b00000;
      end else begin
         state      <= nextState;
         rowIdx     <= rowNext;
         colIdx     <= colNext;
         colLatched <= colLatchedNext;
         divCnt     <= divNext;
         newkey     <= newkeyNext;
         // Row and column are still the latched ones on the DEBOUNCE->EMIT edge
         if (nextState == EMIT) begin
            keycode <= keyEncode({rowIdx, colIdx});
         end
      end
   end

   always_comb begin
      nextState      = state;
      rowNext        = rowIdx;
      colNext        = colIdx;
      colLatchedNext = colLatched;
      divNext        = '0;
      case (state)
         SCAN: begin
            if (divCnt == DIV_LAST) begin
               if (oneColLow(colS)) begin
                  nextState      = DEBOUNCE;
                  colNext        = lowColIndex(colS);
                  colLatchedNext = colS;
               end else begin
                  rowNext = nextRow(rowIdx);
               end
            end else begin
               divNext = divCnt + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (!match) begin
               nextState = SCAN;
               rowNext   = nextRow(rowIdx);
            end else if (stable) begin
               nextState = EMIT;
            end
         end
         EMIT: begin
            nextState = RELEASE;
         end
         RELEASE: begin
            if (stable) begin
               nextState = SCAN;
               rowNext   = nextRow(rowIdx);
            end
         end
         default: begin
            nextState = SCAN;
         end
      endcase
      newkeyNext = (nextState == EMIT) || repFire;
   end

`ifdef KEYPAD_REPEAT_EN
   localparam int               REP_W    = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

   logic [REP_W-1:0] repCnt;
   logic             repRun;

   // Counting starts in EMIT so repeat strobes land REPEAT_CYCLES apart from
   // the first strobe.
   assign repRun  = ((state == EMIT) || (state == RELEASE)) && (colS == colLatched);
   assign repFire = (state == RELEASE) && repRun && (repCnt == REP_LAST);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         repCnt <= '0;
      end else if (!repRun || repFire) begin
         repCnt <= '0;
      end else if (repCnt != REP_LAST) begin
         repCnt <= repCnt + 1'b1;
      end
   end
`else
   assign repFire = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_encoder.sv
// -----------------------------------------------------------------------------
// tb_keypad_encoder
// Directed bench for keypad_encoder with a behavioural key matrix model.
// -----------------------------------------------------------------------------
module tb_keypad_encoder;

   localparam int SCAN_DIV = 4;

   logic       clock;
   logic       reset;
   logic [5:0] row_drive;
   logic [3:0] col_in;
   logic       newkey;
   logic [4:0] keycode;

   logic [23:0] pressMask;

   int tests;
   int failed;
   int pulseCount;
   int cyc;
   int pulseTimes[$];
   logic [4:0] lastCode;

   typedef struct {
      int         row;
      int         col;
      logic [4:0] code;
   } vec_t;

   vec_t vecs[12];

   keypad_encoder #(
      .SCAN_DIV        (SCAN_DIV),
      .DEBOUNCE_CYCLES (8),
      .REPEAT_CYCLES   (20)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .row_drive (row_drive),
      .col_in    (col_in),
      .newkey    (newkey),
      .keycode   (keycode)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Key matrix: a pressed key pulls its column low while its row is driven
   always_comb begin
      col_in = 4'b1111;
      for (int r = 0; r < 6; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressMask[r*4+c] && !row_drive[r]) col_in[c] = 1'b0;
         end
      end
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clock);
         cyc++;
      end
   end

   // Strobe monitor
   initial begin
      logic       prevNewkey;
      logic       prevReset;
      logic [4:0] prevKeycode;
      prevNewkey  = 1'b0;
      prevReset   = 1'b0;
      prevKeycode = 5'b00000;
      forever begin
         @(negedge clock);
         if (newkey) begin
            tests++;
            if (prevNewkey) begin
               failed++;
               $display("FAIL newkey_back_to_back: newkey got 1 on consecutive cycles, required 0");
            end
            pulseCount++;
            lastCode = keycode;
            pulseTimes.push_back(cyc);
         end
         if (reset && prevReset && !newkey && keycode !== prevKeycode) begin
            tests++;
            failed++;
            $display("FAIL keycode_hold: keycode got %b without newkey, required %b", keycode, prevKeycode);
         end
         prevNewkey  = newkey;
         prevKeycode = keycode;
         prevReset   = reset;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clock);
         #1;
      end
   endtask

   task automatic waitPulses(input int target, input int budget, input string name);
      int n;
      n = 0;
      while (pulseCount < target && n < budget) begin
         step(1);
         n++;
      end
      tests++;
      if (pulseCount < target) begin
         failed++;
         $display("FAIL %s: timeout with %0d pulses, required %0d", name, pulseCount, target);
      end
   endtask

   task automatic waitRow0(input string name);
      int n;
      n = 0;
      while (row_drive !== 6'b111110 && n < 40) begin
         step(1);
         n++;
      end
      check(name, row_drive, 6'b111110);
   endtask

   initial begin
      int n;
      int run;
      tests      = 0;
      failed     = 0;
      pulseCount = 0;
      lastCode   = 5'b00000;
      pressMask  = '0;
      reset      = 1'b0;

      vecs[0]  = '{1, 2, 5'b10110};
      vecs[1]  = '{5, 3, 5'b00011};
      vecs[2]  = '{4, 0, 5'b01001};
      vecs[3]  = '{0, 0, 5'b10000};
      vecs[4]  = '{3, 3, 5'b11111};
      vecs[5]  = '{4, 1, 5'b01010};
      vecs[6]  = '{4, 2, 5'b01011};
      vecs[7]  = '{4, 3, 5'b01100};
      vecs[8]  = '{5, 0, 5'b00100};
      vecs[9]  = '{5, 1, 5'b00001};
      vecs[10] = '{5, 2, 5'b00010};
      vecs[11] = '{2, 1, 5'b11001};

      #3;
      check("reset_row_drive", row_drive, 6'b111110);
      check("reset_newkey", newkey, 1'b0);
      check("reset_keycode", keycode, 5'b00000);
      step(3);
      reset = 1'b1;
      step(5);
      check("idle_no_pulse", pulseCount, 0);

      // Single presses, one pulse each with the mapped keycode
      for (int i = 0; i < 12; i++) begin
         pulseCount = 0;
         pressMask[vecs[i].row*4 + vecs[i].col] = 1'b1;
         waitPulses(1, 60, $sformatf("vec%0d_pulse", i));
         check($sformatf("vec%0d_code", i), lastCode, vecs[i].code);
         step(5);
         pressMask = '0;
         step(25);
         check($sformatf("vec%0d_count", i), pulseCount, 1);
         check($sformatf("vec%0d_held", i), keycode, vecs[i].code);
      end

      // Contact bounce on row0/col0
      pulseCount = 0;
      waitRow0("bounce_row0");
      pressMask[0] = 1'b1; step(3);
      pressMask[0] = 1'b0; step(2);
      pressMask[0] = 1'b1; step(3);
      check("bounce_no_pulse", pulseCount, 0);
      waitPulses(1, 60, "bounce_pulse");
      check("bounce_code", lastCode, 5'b10000);
      step(5);
      pressMask = '0;
      step(25);
      check("bounce_count", pulseCount, 1);

      // Keys in rows 2 and 3 together: row2 scanned first wins
      pulseCount = 0;
      waitRow0("dual_row0");
      pressMask[8]  = 1'b1;
      pressMask[13] = 1'b1;
      waitPulses(1, 60, "dual_pulse");
      check("dual_code", lastCode, 5'b11000);
      step(15);
      check("dual_held_count", pulseCount, 1);
      pressMask = '0;
      step(25);
      check("dual_release_count", pulseCount, 1);
      pressMask[13] = 1'b1;
      waitPulses(2, 60, "dual_second_pulse");
      check("dual_second_code", lastCode, 5'b11101);
      step(5);
      pressMask = '0;
      step(25);
      check("dual_second_count", pulseCount, 2);

      // Reset during debounce of key 9
      pulseCount = 0;
      pressMask[9] = 1'b1;
      n   = 0;
      run = 0;
      while (run < SCAN_DIV + 2 && n < 60) begin
         step(1);
         n++;
         if (row_drive === 6'b111011) run++;
         else run = 0;
      end
      check("rst_in_debounce", run, SCAN_DIV + 2);
      check("rst_no_early_pulse", pulseCount, 0);
      reset = 1'b0;
      #1;
      check("rst_row_drive", row_drive, 6'b111110);
      check("rst_newkey", newkey, 1'b0);
      check("rst_keycode", keycode, 5'b00000);
      step(2);
      pressMask = '0;
      step(2);
      reset = 1'b1;
      step(20);
      check("rst_no_pulse_after", pulseCount, 0);
      pressMask[9] = 1'b1;
      waitPulses(1, 60, "rst_fresh_pulse");
      check("rst_fresh_code", lastCode, 5'b11001);
      step(5);
      pressMask = '0;
      step(25);

      // Long hold of key F
      pulseCount = 0;
      pulseTimes.delete();
      pressMask[15] = 1'b1;
      waitPulses(1, 60, "hold_pulse");
      check("hold_code", lastCode, 5'b11111);
      step(79);
`ifdef KEYPAD_REPEAT_EN
      check("hold_repeat_count", pulseCount, 4);
      for (int i = 1; i < pulseTimes.size(); i++) begin
         check($sformatf("hold_interval%0d", i), pulseTimes[i] - pulseTimes[i-1], 20);
      end
      check("hold_repeat_code", lastCode, 5'b11111);
`else
      check("hold_single_count", pulseCount, 1);
`endif
      pressMask = '0;
      step(25);
      check("hold_final_code", keycode, 5'b11111);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
